// File: rtl/video_timing_gen.sv
// Multi-mode raster timing generator (640x480, 1280x720, 1920x1080 @60); optional frame counter under VTG_FRAME_CNT_EN.
// Latency: every output is one register stage after the internal hc/vc counters, and all outputs describe the same pixel.
// Backpressure: none. The generator free-runs on clk_pix, and mode requests are queued until the next frame boundary.
module video_timing_gen #(
  parameter int WIDTH        = 12,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [1:0]       mode_sel,
  input  logic             mode_req,
  output logic             mode_busy,
  output logic [1:0]       mode_active,
  output logic [WIDTH-1:0] sx,
  output logic [WIDTH-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  if (WIDTH < 12) begin : g_width_chk
    $error("video_timing_gen: WIDTH must be >= 12");
  end

  // Out-of-range DEFAULT_MODE values fall back to 640x480.
  localparam logic [1:0] DEF_MODE = (DEFAULT_MODE == 1) ? 2'd1 :
                                    (DEFAULT_MODE == 2) ? 2'd2 : 2'd0;
  // Sync is held at the inactive level of the default mode while in reset.
  localparam logic DEF_SYNC_IDLE = (DEF_MODE == 2'd0);

  logic [WIDTH-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [1:0]       mode_q, mode_d, pend_q, pend_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] sx_q, sx_d, sy_q, sy_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             de_q, de_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [1:0]       mode_active_q, mode_active_d;

  // Timing values for the mode in force.
  // "ss" is the first sync pixel/line, and "se" is the first pixel/line after sync.
  logic [WIDTH-1:0] h_act, h_ss, h_se, h_tot, v_act, v_ss, v_se, v_tot;
  logic             pol;
  logic             h_last, v_last, wrap, in_hs, in_vs;

  // Select the timing table row of the current internal mode.
  always_comb begin
    h_act = WIDTH'(640);  h_ss = WIDTH'(656);  h_se = WIDTH'(752);  h_tot = WIDTH'(800);
    v_act = WIDTH'(480);  v_ss = WIDTH'(490);  v_se = WIDTH'(492);  v_tot = WIDTH'(525);
    pol   = 1'b0;
    case (mode_q)
      2'd1: begin
        h_act = WIDTH'(1280); h_ss = WIDTH'(1390); h_se = WIDTH'(1430); h_tot = WIDTH'(1650);
        v_act = WIDTH'(720);  v_ss = WIDTH'(725);  v_se = WIDTH'(730);  v_tot = WIDTH'(750);
        pol   = 1'b1;
      end
      2'd2: begin
        h_act = WIDTH'(1920); h_ss = WIDTH'(2008); h_se = WIDTH'(2052); h_tot = WIDTH'(2200);
        v_act = WIDTH'(1080); v_ss = WIDTH'(1084); v_se = WIDTH'(1089); v_tot = WIDTH'(1125);
        pol   = 1'b1;
      end
      default: ;
    endcase
  end

  // Advance the counters, track a pending mode request, and apply it at the frame wrap.
  always_comb begin
    h_last = (hc_q == h_tot - 1'b1);
    v_last = (vc_q == v_tot - 1'b1);
    wrap   = h_last & v_last;
    hc_d   = h_last ? '0 : hc_q + 1'b1;
    vc_d   = vc_q;
    if (h_last) begin
      vc_d = v_last ? '0 : vc_q + 1'b1;
    end
    // At the wrap, the mode takes the value that was pending before this edge.
    // A request on that same edge stays pending for the following frame.
    mode_d = (wrap && busy_q) ? pend_q : mode_q;
    pend_d = pend_q;
    if (mode_req) begin
      pend_d = (mode_sel == 2'd3) ? 2'd0 : mode_sel;
    end
    busy_d = mode_req | (busy_q & ~wrap);
  end

  // Decode the current counter position into the next output register values.
  always_comb begin
    in_hs         = (hc_q >= h_ss) && (hc_q < h_se);
    in_vs         = (vc_q >= v_ss) && (vc_q < v_se);
    sx_d          = hc_q;
    sy_d          = vc_q;
    hsync_d       = ~(in_hs ^ pol);
    vsync_d       = ~(in_vs ^ pol);
    de_d          = (hc_q < h_act) && (vc_q < v_act);
    line_start_d  = (hc_q == '0);
    frame_start_d = (hc_q == '0) && (vc_q == '0);
    mode_active_d = mode_q;
  end

  // Counter, mode and output registers, with a full synchronous restart on reset.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      hc_q          <= '0;
      vc_q          <= '0;
      mode_q        <= DEF_MODE;
      pend_q        <= DEF_MODE;
      busy_q        <= 1'b0;
      sx_q          <= '0;
      sy_q          <= '0;
      hsync_q       <= DEF_SYNC_IDLE;
      vsync_q       <= DEF_SYNC_IDLE;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      mode_active_q <= DEF_MODE;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      mode_q        <= mode_d;
      pend_q        <= pend_d;
      busy_q        <= busy_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      mode_active_q <= mode_active_d;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] fseen_q, fseen_d, frame_cnt_q, frame_cnt_d;

  // On each frame_start, present the number of frames started earlier, so the first frame shows 0.
  always_comb begin
    fseen_d     = fseen_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = fseen_q;
      fseen_d     = fseen_q + 16'd1;
    end
  end

  // Frame counter registers.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      fseen_q     <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      fseen_q     <= fseen_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  assign mode_busy   = busy_q;
  assign mode_active = mode_active_q;
  assign sx          = sx_q;
  assign sy          = sy_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a reference raster model predicts every output per edge through a scoreboard queue.
// Latency: predictions are pushed before each edge and compared 1 time unit after it.
// Backpressure: none. Long stretches of blanking are skipped by forcing the internal counters to a new position.
module tb_video_timing_gen;

  typedef struct packed {
    logic [11:0] sx;
    logic [11:0] sy;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [1:0]  mact;
    logic        busy;
    logic [15:0] fcnt;
  } obs_t;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [1:0]  mode_sel;
  logic        mode_req;
  logic        mode_busy;
  logic [1:0]  mode_active;
  logic [11:0] sx, sy;
  logic        hsync, vsync, de, line_start, frame_start;
  logic [15:0] frame_cnt;

  always #5 clk_pix = ~clk_pix;

  video_timing_gen #(.WIDTH(12), .DEFAULT_MODE(0)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .mode_sel(mode_sel), .mode_req(mode_req),
    .mode_busy(mode_busy), .mode_active(mode_active), .sx(sx), .sy(sy),
    .hsync(hsync), .vsync(vsync), .de(de), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  // Reference timing table: ACT / FP / SYNC / BP, and sync polarity (1 = active-high).
  int h_act_t [3] = '{640, 1280, 1920};
  int h_fp_t  [3] = '{16, 110, 88};
  int h_sy_t  [3] = '{96, 40, 44};
  int h_bp_t  [3] = '{48, 220, 148};
  int v_act_t [3] = '{480, 720, 1080};
  int v_fp_t  [3] = '{10, 5, 4};
  int v_sy_t  [3] = '{2, 5, 5};
  int v_bp_t  [3] = '{33, 20, 36};
  bit pol_t   [3] = '{1'b0, 1'b1, 1'b1};

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state.
  int m_hc, m_vc, m_mode, m_pend, m_fseen, m_fcnt;
  bit m_busy;

  // Statistics collected over a measurement window.
  bit hs_lvl, vs_lvl;
  int cyc, n_de, n_hs, first_hs, last_hs, n_vs, first_vs, last_vs, last_ls, ls_gap;
  bit saw_m1;
  logic [11:0] jh, jv;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic clr_stats(input bit hl, input bit vl);
    hs_lvl = hl; vs_lvl = vl;
    n_de = 0; n_hs = 0; first_hs = -1; last_hs = -1;
    n_vs = 0; first_vs = -1; last_vs = -1; last_ls = -1; ls_gap = -1; saw_m1 = 0;
  endtask

  // Predict the outputs loaded by the next edge and advance the model.
  task automatic model_edge(output obs_t e);
    int ht, vt, hss, vss, nmode;
    bit hin, vin, wrap;
    e = '0;
    if (rst_pix) begin
      e.hs = 1'b1; e.vs = 1'b1;
      m_hc = 0; m_vc = 0; m_mode = 0; m_pend = 0; m_busy = 0; m_fseen = 0; m_fcnt = 0;
      return;
    end
    ht  = h_act_t[m_mode] + h_fp_t[m_mode] + h_sy_t[m_mode] + h_bp_t[m_mode];
    vt  = v_act_t[m_mode] + v_fp_t[m_mode] + v_sy_t[m_mode] + v_bp_t[m_mode];
    hss = h_act_t[m_mode] + h_fp_t[m_mode];
    vss = v_act_t[m_mode] + v_fp_t[m_mode];
    hin = (m_hc >= hss) && (m_hc < hss + h_sy_t[m_mode]);
    vin = (m_vc >= vss) && (m_vc < vss + v_sy_t[m_mode]);
    e.sx   = 12'(m_hc);
    e.sy   = 12'(m_vc);
    e.hs   = pol_t[m_mode] ? hin : !hin;
    e.vs   = pol_t[m_mode] ? vin : !vin;
    e.de   = (m_hc < h_act_t[m_mode]) && (m_vc < v_act_t[m_mode]);
    e.ls   = (m_hc == 0);
    e.fs   = (m_hc == 0) && (m_vc == 0);
    e.mact = 2'(m_mode);
`ifdef VTG_FRAME_CNT_EN
    if (e.fs) begin
      m_fcnt  = m_fseen;
      m_fseen = (m_fseen + 1) % 65536;
    end
    e.fcnt = 16'(m_fcnt);
`endif
    wrap  = (m_hc == ht - 1) && (m_vc == vt - 1);
    nmode = (wrap && m_busy) ? m_pend : m_mode;
    if (m_hc == ht - 1) begin
      m_hc = 0;
      m_vc = (m_vc == vt - 1) ? 0 : m_vc + 1;
    end else begin
      m_hc++;
    end
    if (mode_req) begin
      m_pend = (mode_sel == 2'd3) ? 0 : int'(mode_sel);
      m_busy = 1;
    end else if (wrap) begin
      m_busy = 0;
    end
    e.busy = m_busy;
    m_mode = nmode;
  endtask

  // One clock: push the prediction, let the edge happen, pop and compare, then return at the negedge.
  task automatic step();
    obs_t e, a, x;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge clk_pix);
    #1;
    a = {sx, sy, hsync, vsync, de, line_start, frame_start, mode_active, mode_busy, frame_cnt};
    x = exp_q.pop_front();
    chk_eq($sformatf("pix(%0d,%0d)", x.sx, x.sy), a, x);
    if (de) n_de++;
    if (hsync == hs_lvl) begin n_hs++; if (first_hs < 0) first_hs = sx; last_hs = sx; end
    if (vsync == vs_lvl) begin n_vs++; if (first_vs < 0) first_vs = sy; last_vs = sy; end
    if (line_start) begin if (last_ls >= 0) ls_gap = cyc - last_ls; last_ls = cyc; end
    if (mode_active == 2'd1) saw_m1 = 1;
    cyc++;
    mode_req = 1'b0;
    @(negedge clk_pix);
  endtask

  // Move the raster to (h,v); the next edge outputs that pixel.
  task automatic jump(input int h, input int v);
    jh = 12'(h); jv = 12'(v);
    m_hc = h; m_vc = v;
    force dut.hc_q = jh;
    force dut.vc_q = jv;
    #1;
    release dut.hc_q;
    release dut.vc_q;
  endtask

  task automatic run_until_fs(input int budget, input string tag);
    int n = 0;
    do begin step(); n++; end while (!frame_start && n < budget);
    chk_eq(tag, frame_start, 1'b1);
  endtask

  task automatic req(input logic [1:0] m);
    mode_sel = m; mode_req = 1'b1;
    step();
  endtask

  initial begin
    cyc = 0;
    rst_pix = 1'b1; mode_req = 1'b0; mode_sel = 2'd0;
    clr_stats(1'b0, 1'b0);
    step(); step();
    chk_eq("rst_pos", {sx, sy}, 24'd0);
    chk_eq("rst_strobes", {de, line_start, frame_start}, 3'b000);
    chk_eq("rst_sync_idle", {hsync, vsync}, 2'b11);
    chk_eq("rst_mode", {mode_active, mode_busy}, 3'b000);
    chk_eq("rst_fcnt", frame_cnt, 16'd0);

    // 640x480: first line after release.
    rst_pix = 1'b0;
    clr_stats(1'b0, 1'b0);
    step();
    chk_eq("first_px", {sx, sy, de, line_start, frame_start}, {24'd0, 3'b111});
    repeat (799) step();
    chk_eq("m0_de_line", n_de, 640);
    chk_eq("m0_hs_len", n_hs, 96);
    chk_eq("m0_hs_span", {first_hs[11:0], last_hs[11:0]}, {12'd656, 12'd751});

    // 640x480: vertical blanking and vsync lines.
    jump(0, 488);
    clr_stats(1'b0, 1'b0);
    repeat (800 * 5) step();
    chk_eq("m0_vs_cycles", n_vs, 1600);
    chk_eq("m0_vs_span", {first_vs[11:0], last_vs[11:0]}, {12'd490, 12'd491});
    chk_eq("m0_vblank_de", n_de, 0);

    // Request mode 2 mid-frame; it is applied at the next frame boundary.
    jump(0, 523);
    repeat (100) step();
    req(2'd2);
    chk_eq("busy_set", mode_busy, 1'b1);
    run_until_fs(2000, "m2_fs_timeout");
    chk_eq("m2_applied", {mode_active, mode_busy}, {2'd2, 1'b0});
    clr_stats(1'b1, 1'b1);
    repeat (4400) step();
    chk_eq("m2_htot", ls_gap, 2200);
    chk_eq("m2_hs_len", n_hs, 88);
    chk_eq("m2_hs_span", {first_hs[11:0], last_hs[11:0]}, {12'd2008, 12'd2051});

    // Two requests in one frame: the last one wins, and the first is never seen.
    jump(0, 1124);
    repeat (10) step();
    req(2'd1);
    repeat (5) step();
    req(2'd0);
    clr_stats(1'b0, 1'b0);
    run_until_fs(3000, "lastwin_fs_timeout");
    chk_eq("lastwin_mode", mode_active, 2'd0);
    repeat (20) step();
    chk_eq("lastwin_no_m1", saw_m1, 1'b0);
    chk_eq("lastwin_busy", mode_busy, 1'b0);

    // A request on the wrap edge itself waits one more frame.
    jump(797, 524);
    step(); step();
    req(2'd1);
    step();
    chk_eq("wrapreq_fs", frame_start, 1'b1);
    chk_eq("wrapreq_old_mode", {mode_active, mode_busy}, {2'd0, 1'b1});
    jump(790, 524);
    run_until_fs(100, "wrapreq_fs2_timeout");
    chk_eq("wrapreq_new_mode", {mode_active, mode_busy}, {2'd1, 1'b0});

    // 1280x720: a few more frame boundaries for the frame counter.
    for (int f = 0; f < 2; f++) begin
      jump(1640, 749);
      run_until_fs(50, "m1_fs_timeout");
    end
`ifdef VTG_FRAME_CNT_EN
    chk_eq("fcnt_m1", frame_cnt, 16'd6);
`else
    chk_eq("fcnt_off", frame_cnt, 16'd0);
`endif

    // Reset mid-frame with a request pending: a full restart in the default mode.
    jump(300, 200);
    repeat (5) step();
    req(2'd2);
    chk_eq("rst_mid_busy_pre", mode_busy, 1'b1);
    rst_pix = 1'b1;
    step();
    rst_pix = 1'b0;
    step();
    chk_eq("rst_mid_pos", {sx, sy, frame_start}, {24'd0, 1'b1});
    chk_eq("rst_mid_mode", {mode_active, mode_busy}, {2'd0, 1'b0});
    chk_eq("rst_mid_fcnt", frame_cnt, 16'd0);
    repeat (50) step();
    chk_eq("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
